// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment controller: load handshake, sequential binary-to-BCD conversion, scanned display.
// Optional SEG_LZB_EN enables leading-zero blanking of the upper digits.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned VAL_W    = 27,
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VAL_W-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    input  logic [DIGITS-1:0] digit_en,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic              power,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);
    // (VAL_W+2)/3 nibbles always cover 2^VAL_W-1 since each decimal digit spans >3 bits
    localparam int unsigned BCD_N = (((VAL_W + 2) / 3) > DIGITS) ? ((VAL_W + 2) / 3) : DIGITS;
    localparam int unsigned BCD_W = BCD_N * 4;
    localparam int unsigned CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [VAL_W-1:0]         bin_q, bin_d;
    logic [BCD_N-1:0][3:0]    bcd_q, bcd_d, bcd_adj;
    logic [DIGITS-1:0][3:0]   buf_q, buf_d;
    logic                     busy_d, ovf_d;
    logic [PRE_W-1:0]         pre_q, pre_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [7:0]               seg_d;
    logic [DIGITS-1:0]        an_d;
    logic                     lz;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Conversion FSM: next state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        buf_d   = buf_q;
        busy_d  = busy;
        ovf_d   = ovf;
        for (int i = 0; i < BCD_N; i++) begin
            bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(VAL_W - 1);
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = BCD_W'({bcd_adj, bin_q[VAL_W-1]});
                bin_d = bin_q << 1;
                if (cnt_q == '0) begin
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_COMMIT: begin
                buf_d = bcd_q[DIGITS-1:0];
                ovf_d = 1'b0;
                for (int i = DIGITS; i < BCD_N; i++) begin
                    if (bcd_q[i] != 4'd0) ovf_d = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan prescaler and digit index
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Anode/segment drive for the current digit
    always_comb begin
        an_d  = '1;
        seg_d = '1;
        lz    = 1'b0;
`ifdef SEG_LZB_EN
        lz = (idx_q != '0) && !ovf;
        for (int i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_q) && (buf_q[i] != 4'd0)) lz = 1'b0;
        end
`endif
        if (power && digit_en[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d[7]    = ~dp_mask[idx_q];
            if (ovf) begin
                seg_d[6:0] = 7'b0111111;
            end else if (!lz) begin
                seg_d[6:0] = dec7(buf_q[idx_q]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            buf_q   <= '0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            seg     <= '1;
            an      <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            buf_q   <= buf_d;
            busy    <= busy_d;
            ovf     <= ovf_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            seg     <= seg_d;
            an      <= an_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a decimal-arithmetic reference model.
module tb_seg_scan_ctrl;
    localparam int unsigned DIGITS   = 8;
    localparam int unsigned VAL_W    = 27;
    localparam int unsigned SCAN_DIV = 4;
`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [VAL_W-1:0]  value;
    logic              load;
    logic              busy, ovf;
    logic [DIGITS-1:0] digit_en, dp_mask, an;
    logic              power;
    logic [7:0]        seg;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(DIGITS), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy), .ovf(ovf),
        .digit_en(digit_en), .dp_mask(dp_mask), .power(power), .seg(seg), .an(an)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint pow10(input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    // Active-low a..g patterns for decimal digits 0..9
    logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model: edge count gives the scanned digit, committed value gives the decimal digits
    longint            m_n, m_pend, m_cur;
    bit                m_busy, m_ovf;
    int                m_left, m_ix;
    logic [DIGITS-1:0] exp_an;
    logic [7:0]        exp_seg;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_n = 0; m_busy = 0; m_ovf = 0; m_left = 0; m_cur = 0; m_pend = 0;
            exp_an = '1; exp_seg = '1;
        end else begin
            m_ix    = int'((m_n / SCAN_DIV) % DIGITS);
            exp_an  = '1;
            exp_seg = '1;
            if (power && digit_en[m_ix]) begin
                exp_an[m_ix] = 1'b0;
                exp_seg[7]   = ~dp_mask[m_ix];
                if (m_ovf)
                    exp_seg[6:0] = 7'h3F;
                else if (!(LZB && m_ix > 0 && m_cur < pow10(m_ix)))
                    exp_seg[6:0] = pat[int'((m_cur / pow10(m_ix)) % 10)];
            end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_cur  = m_pend;
                    m_ovf  = (m_pend >= pow10(DIGITS));
                end
            end else if (load) begin
                m_busy = 1;
                m_left = VAL_W + 1;
                m_pend = longint'(value);
            end
            m_n++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check_eq("an",   32'(an),   32'(exp_an));
            check_eq("seg",  32'(seg),  32'(exp_seg));
            check_eq("busy", 32'(busy), 32'(m_busy));
            check_eq("ovf",  32'(ovf),  32'(m_ovf));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_ovf",  32'(ovf),  32'h0);
        check_eq("rst_an",   32'(an),   32'hFF);
        check_eq("rst_seg",  32'(seg),  32'hFF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_val(input longint v);
        @(negedge clk);
        value = VAL_W'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0;
        digit_en = '1; dp_mask = '0; power = 1'b1;
        chk_en = 1'b1;
        do_reset();
        run(3 * DIGITS * SCAN_DIV);

        load_val(12345678);
        run(VAL_W + 2 + 2 * DIGITS * SCAN_DIV);

        load_val(100000000);
        run(3);
        load_val(5);
        run(VAL_W + 2 * DIGITS * SCAN_DIV);

        load_val(42);
        run(VAL_W + 2 + 2 * DIGITS * SCAN_DIV);

        @(negedge clk);
        digit_en = 8'h0F; dp_mask = 8'h04;
        run(2 * DIGITS * SCAN_DIV);
        power = 1'b0;
        run(DIGITS * SCAN_DIV);
        power = 1'b1;
        run(2 * DIGITS * SCAN_DIV);
        digit_en = '1; dp_mask = '0;

        load_val(777);
        run(10);
        do_reset();
        run(DIGITS * SCAN_DIV);
        load_val(9876543);
        run(VAL_W + 2 + 2 * DIGITS * SCAN_DIV);

        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 2))
                0:       load_val(longint'($urandom_range(0, 999)));
                1:       load_val(longint'($urandom_range(0, 99999999)));
                default: load_val(longint'($urandom & 32'h07FF_FFFF));
            endcase
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) digit_en = DIGITS'($urandom);
            if ($urandom_range(0, 3) == 0) dp_mask  = DIGITS'($urandom);
            power = ($urandom_range(0, 7) != 0);
            run(int'($urandom_range(1, 40)));
            if (it % 60 == 59) do_reset();
        end

        power = 1'b1; digit_en = '1;
        run(VAL_W + 4);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
